// File: rtl/polara_loopback_packet_chk_if.sv
// Flit bundle from the chip to the loopback checker: three NoC channels,
// each with 64-bit data, a valid from the chip and a ready back to the chip.
//   master : chip side, drives data/valid and observes ready
//   slave  : checker side, observes data/valid and drives ready
interface polara_loopback_packet_chk_if;
    logic [63:0] intf_chipset_data_noc1;
    logic [63:0] intf_chipset_data_noc2;
    logic [63:0] intf_chipset_data_noc3;
    logic        intf_chipset_val_noc1;
    logic        intf_chipset_val_noc2;
    logic        intf_chipset_val_noc3;
    logic        intf_chipset_rdy_noc1;
    logic        intf_chipset_rdy_noc2;
    logic        intf_chipset_rdy_noc3;

    modport master (
        output intf_chipset_data_noc1, intf_chipset_data_noc2, intf_chipset_data_noc3,
        output intf_chipset_val_noc1, intf_chipset_val_noc2, intf_chipset_val_noc3,
        input  intf_chipset_rdy_noc1, intf_chipset_rdy_noc2, intf_chipset_rdy_noc3
    );

    modport slave (
        input  intf_chipset_data_noc1, intf_chipset_data_noc2, intf_chipset_data_noc3,
        input  intf_chipset_val_noc1, intf_chipset_val_noc2, intf_chipset_val_noc3,
        output intf_chipset_rdy_noc1, intf_chipset_rdy_noc2, intf_chipset_rdy_noc3
    );
endinterface

// File: rtl/polara_loopback_packet_chk.sv
// Loopback packet checker. Sinks flits on three NoC channels (never
// backpressures), parses packets on the channel chosen by sw_debounced,
// checks header fields against expected values and counts good/bad packets.
//
// Ports:
//   chipset_clk    clock, all state on rising edge
//   chipset_rst_n  asynchronous active-low reset
//   sw_debounced   channel select: 01=noc1, 10=noc2, 11=noc3, 00=none
//   clr            synchronous clear of counters, status and FSM
//   noc            flit interface (slave side)
//   pkt_cnt        completed packets, saturating
//   err_cnt        bad packets (and timeouts when enabled), saturating
//   err_flag       sticky error indication
//   last_hdr       most recently accepted header flit
//
// Optional feature: define POLARA_LOOPBACK_CHK_TIMEOUT_EN to abort a packet
// that sits TIMEOUT_CYC consecutive cycles in payload without a flit.
module polara_loopback_packet_chk #(
    parameter logic [13:0] EXP_CHIPID   = 14'b10000000000000,
    parameter logic [7:0]  EXP_MSG_TYPE = 8'd18,
    parameter logic [3:0]  EXP_FBITS    = 4'b0010,
    parameter int unsigned TIMEOUT_CYC  = 1024
) (
    input  logic                          chipset_clk,
    input  logic                          chipset_rst_n,
    input  logic [1:0]                    sw_debounced,
    input  logic                          clr,
    polara_loopback_packet_chk_if.slave   noc,
    output logic [15:0]                   pkt_cnt,
    output logic [7:0]                    err_cnt,
    output logic                          err_flag,
    output logic [63:0]                   last_hdr
);

    typedef enum logic [0:0] {StHdr, StPayload} state_e;

    state_e      r_state, w_state_d;
    logic [7:0]  r_rem, w_rem_d;
    logic        r_bad, w_bad_d;
    logic [1:0]  r_sel_prev;
    logic        r_rdy;
    logic [15:0] r_pkt_cnt;
    logic [7:0]  r_err_cnt;
    logic        r_err_flag;
    logic [63:0] r_last_hdr;

    logic [63:0] w_sel_data;
    logic        w_sel_val;
    logic        w_acc;
    logic        w_sel_chg;
    logic        w_hdr_bad;
    logic        w_load_hdr;
    logic        w_done;
    logic        w_timeout;

    // Sink is always ready once out of reset.
    assign noc.intf_chipset_rdy_noc1 = r_rdy;
    assign noc.intf_chipset_rdy_noc2 = r_rdy;
    assign noc.intf_chipset_rdy_noc3 = r_rdy;

    always_comb begin
        w_sel_data = 64'd0;
        w_sel_val  = 1'b0;
        unique case (sw_debounced)
            2'b01: begin
                w_sel_data = noc.intf_chipset_data_noc1;
                w_sel_val  = noc.intf_chipset_val_noc1;
            end
            2'b10: begin
                w_sel_data = noc.intf_chipset_data_noc2;
                w_sel_val  = noc.intf_chipset_val_noc2;
            end
            2'b11: begin
                w_sel_data = noc.intf_chipset_data_noc3;
                w_sel_val  = noc.intf_chipset_val_noc3;
            end
            default: ;
        endcase
    end

    assign w_acc     = w_sel_val & r_rdy;
    assign w_sel_chg = (sw_debounced != r_sel_prev);
    assign w_hdr_bad = (w_sel_data[63:50] != EXP_CHIPID)   ||
                       (w_sel_data[21:14] != EXP_MSG_TYPE) ||
                       (w_sel_data[33:30] != EXP_FBITS)    ||
                       (w_sel_data[5:0]   != 6'd0);

`ifdef POLARA_LOOPBACK_CHK_TIMEOUT_EN
    logic [31:0] r_idle;
    logic [31:0] w_idle_d;
    logic        w_idle_hit;

    assign w_idle_hit = (r_idle == 32'(TIMEOUT_CYC - 1));
    // Counts idle cycles only while remaining in payload; any acceptance,
    // entry to payload or exit clears it.
    assign w_idle_d = (r_state == StPayload && !w_acc && w_state_d == StPayload) ?
                      r_idle + 32'd1 : 32'd0;

    always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
        if (!chipset_rst_n) begin
            r_idle <= 32'd0;
        end else if (clr) begin
            r_idle <= 32'd0;
        end else begin
            r_idle <= w_idle_d;
        end
    end
`else
    logic w_unused_timeout;
    logic w_idle_hit;
    assign w_unused_timeout = ^32'(TIMEOUT_CYC);
    assign w_idle_hit       = 1'b0;
`endif

    // Next-state: a select change overrides everything and drops the packet.
    always_comb begin
        w_state_d  = r_state;
        w_rem_d    = r_rem;
        w_bad_d    = r_bad;
        w_load_hdr = 1'b0;
        w_done     = 1'b0;
        w_timeout  = 1'b0;
        if (w_sel_chg) begin
            w_state_d = StHdr;
            w_bad_d   = 1'b0;
        end else begin
            unique case (r_state)
                StHdr: begin
                    if (w_acc) begin
                        w_load_hdr = 1'b1;
                        w_bad_d    = w_hdr_bad;
                        w_rem_d    = w_sel_data[29:22];
                        if (w_sel_data[29:22] == 8'd0) begin
                            w_done = 1'b1;
                        end else begin
                            w_state_d = StPayload;
                        end
                    end
                end
                StPayload: begin
                    if (w_acc) begin
                        w_rem_d = r_rem - 8'd1;
                        if (r_rem == 8'd1) begin
                            w_done    = 1'b1;
                            w_state_d = StHdr;
                        end
                    end else if (w_idle_hit) begin
                        w_timeout = 1'b1;
                        w_state_d = StHdr;
                    end
                end
                default: w_state_d = StHdr;
            endcase
        end
    end

    always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
        if (!chipset_rst_n) begin
            r_state    <= StHdr;
            r_rem      <= 8'd0;
            r_bad      <= 1'b0;
            r_sel_prev <= 2'b00;
            r_rdy      <= 1'b0;
            r_pkt_cnt  <= 16'd0;
            r_err_cnt  <= 8'd0;
            r_err_flag <= 1'b0;
            r_last_hdr <= 64'd0;
        end else begin
            r_rdy      <= 1'b1;
            r_sel_prev <= sw_debounced;
            if (clr) begin
                r_state    <= StHdr;
                r_rem      <= 8'd0;
                r_bad      <= 1'b0;
                r_pkt_cnt  <= 16'd0;
                r_err_cnt  <= 8'd0;
                r_err_flag <= 1'b0;
                r_last_hdr <= 64'd0;
            end else begin
                r_state <= w_state_d;
                r_rem   <= w_rem_d;
                r_bad   <= w_bad_d;
                if (w_load_hdr) begin
                    r_last_hdr <= w_sel_data;
                end
                if (w_done && r_pkt_cnt != 16'hFFFF) begin
                    r_pkt_cnt <= r_pkt_cnt + 16'd1;
                end
                if ((w_done && w_bad_d) || w_timeout) begin
                    r_err_flag <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign err_cnt  = r_err_cnt;
    assign err_flag = r_err_flag;
    assign last_hdr = r_last_hdr;

endmodule

// File: tb/tb_polara_loopback_packet_chk.sv
module tb_polara_loopback_packet_chk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  sel = 2'b00;
    logic        clr = 1'b0;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;
    logic        err_flag;
    logic [63:0] last_hdr;

    int n_checks = 0;
    int n_errors = 0;

    polara_loopback_packet_chk_if bus ();

    polara_loopback_packet_chk #(
        .TIMEOUT_CYC (16)
    ) dut (
        .chipset_clk   (clk),
        .chipset_rst_n (rst_n),
        .sw_debounced  (sel),
        .clr           (clr),
        .noc           (bus),
        .pkt_cnt       (pkt_cnt),
        .err_cnt       (err_cnt),
        .err_flag      (err_flag),
        .last_hdr      (last_hdr)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk_hdr(input logic [13:0] chip, input logic [3:0] fb,
                                           input logic [7:0] len, input logic [7:0] mt,
                                           input logic [5:0] rsvd);
        return {chip, 8'd0, 8'd0, fb, len, mt, 8'd0, rsvd};
    endfunction

    localparam logic [63:0] GOOD = {14'h2000, 8'd0, 8'd0, 4'b0010, 8'd0, 8'd18, 8'd0, 6'd0};

    // Drive one cycle of flits starting at a negedge; mask bit0=noc1 .. bit2=noc3.
    task automatic drive(input logic [2:0] mask, input logic [63:0] d);
        bus.intf_chipset_data_noc1 = d;
        bus.intf_chipset_data_noc2 = d;
        bus.intf_chipset_data_noc3 = d;
        bus.intf_chipset_val_noc1  = mask[0];
        bus.intf_chipset_val_noc2  = mask[1];
        bus.intf_chipset_val_noc3  = mask[2];
        @(negedge clk);
        bus.intf_chipset_val_noc1  = 1'b0;
        bus.intf_chipset_val_noc2  = 1'b0;
        bus.intf_chipset_val_noc3  = 1'b0;
    endtask

    function automatic logic [2:0] ch_mask(input logic [1:0] s);
        return (s == 2'b01) ? 3'b001 : (s == 2'b10) ? 3'b010 : (s == 2'b11) ? 3'b100 : 3'b000;
    endfunction

    task automatic set_sel(input logic [1:0] s);
        if (sel != s) begin
            sel = s;
            @(negedge clk);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.intf_chipset_rdy_noc1, bus.intf_chipset_rdy_noc2, bus.intf_chipset_rdy_noc3}
            !== 3'b000) begin
            n_errors++; $display("FAIL reset_rdy got %b want 000", {bus.intf_chipset_rdy_noc1,
                bus.intf_chipset_rdy_noc2, bus.intf_chipset_rdy_noc3});
        end
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag, last_hdr} !== 89'd0) begin
            n_errors++; $display("FAIL reset_status got pkt=%h err=%h flag=%b hdr=%h want 0",
                pkt_cnt, err_cnt, err_flag, last_hdr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.intf_chipset_rdy_noc1, bus.intf_chipset_rdy_noc2, bus.intf_chipset_rdy_noc3}
            !== 3'b111) begin
            n_errors++; $display("FAIL rdy_after_reset got %b want 111",
                {bus.intf_chipset_rdy_noc1, bus.intf_chipset_rdy_noc2, bus.intf_chipset_rdy_noc3});
        end
    endtask

    task automatic test_good();
        set_sel(2'b01);
        drive(3'b001, GOOD);
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag} !== {16'd1, 8'd0, 1'b0}) begin
            n_errors++; $display("FAIL good_pkt got pkt=%0d err=%0d flag=%b want 1 0 0",
                pkt_cnt, err_cnt, err_flag);
        end
        n_checks++;
        if (last_hdr !== GOOD) begin
            n_errors++; $display("FAIL good_last_hdr got %h want %h", last_hdr, GOOD);
        end
    endtask

    task automatic test_bad_msg();
        do_clr();
        set_sel(2'b10);
        drive(3'b010, mk_hdr(14'h2000, 4'b0010, 8'd2, 8'd19, 6'd0));
        drive(3'b010, 64'h1111);
        n_checks++;
        if ({pkt_cnt, err_cnt} !== {16'd0, 8'd0}) begin
            n_errors++; $display("FAIL bad_midpkt got pkt=%0d err=%0d want 0 0", pkt_cnt, err_cnt);
        end
        drive(3'b010, 64'h2222);
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag} !== {16'd1, 8'd1, 1'b1}) begin
            n_errors++; $display("FAIL bad_msg_type got pkt=%0d err=%0d flag=%b want 1 1 1",
                pkt_cnt, err_cnt, err_flag);
        end
        for (int i = 0; i < 10; i++) drive(3'b010, GOOD);
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag} !== {16'd11, 8'd1, 1'b1}) begin
            n_errors++; $display("FAIL sticky_flag got pkt=%0d err=%0d flag=%b want 11 1 1",
                pkt_cnt, err_cnt, err_flag);
        end
    endtask

    task automatic test_checks();
        do_clr();
        drive(3'b010, mk_hdr(14'h2001, 4'b0010, 8'd0, 8'd18, 6'd0));
        drive(3'b010, mk_hdr(14'h2000, 4'b0011, 8'd0, 8'd18, 6'd0));
        drive(3'b010, mk_hdr(14'h2000, 4'b0010, 8'd0, 8'd18, 6'd1));
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag} !== {16'd3, 8'd3, 1'b1}) begin
            n_errors++; $display("FAIL field_checks got pkt=%0d err=%0d flag=%b want 3 3 1",
                pkt_cnt, err_cnt, err_flag);
        end
        n_checks++;
        if (last_hdr !== mk_hdr(14'h2000, 4'b0010, 8'd0, 8'd18, 6'd1)) begin
            n_errors++; $display("FAIL rsvd_last_hdr got %h", last_hdr);
        end
    endtask

    task automatic test_unselected();
        do_clr();
        drive(3'b101, GOOD);
        drive(3'b101, mk_hdr(14'h0, 4'b0, 8'd0, 8'd0, 6'd0));
        set_sel(2'b00);
        drive(3'b111, GOOD);
        drive(3'b111, GOOD);
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag, last_hdr} !== 89'd0) begin
            n_errors++; $display("FAIL unselected got pkt=%0d err=%0d flag=%b hdr=%h want 0",
                pkt_cnt, err_cnt, err_flag, last_hdr);
        end
    endtask

    task automatic test_sel_change();
        do_clr();
        set_sel(2'b01);
        drive(3'b001, mk_hdr(14'h2000, 4'b0010, 8'd3, 8'd18, 6'd0));
        drive(3'b001, 64'h5555);
        sel = 2'b10;
        drive(3'b010, GOOD);
        n_checks++;
        if ({pkt_cnt, err_cnt} !== {16'd0, 8'd0}) begin
            n_errors++; $display("FAIL selchg_edge_flit got pkt=%0d err=%0d want 0 0",
                pkt_cnt, err_cnt);
        end
        drive(3'b010, GOOD);
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag, last_hdr} !== {16'd1, 8'd0, 1'b0, GOOD}) begin
            n_errors++; $display("FAIL selchg got pkt=%0d err=%0d flag=%b hdr=%h want 1 0 0 %h",
                pkt_cnt, err_cnt, err_flag, last_hdr, GOOD);
        end
    endtask

    task automatic test_reset_mid();
        set_sel(2'b01);
        drive(3'b001, mk_hdr(14'h2000, 4'b0010, 8'd2, 8'd18, 6'd0));
        drive(3'b001, 64'h7777);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.intf_chipset_rdy_noc1, bus.intf_chipset_rdy_noc2, bus.intf_chipset_rdy_noc3,
             pkt_cnt} !== {3'b000, 16'd0}) begin
            n_errors++; $display("FAIL mid_reset got rdy=%b pkt=%0d want 000 0",
                {bus.intf_chipset_rdy_noc1, bus.intf_chipset_rdy_noc2,
                 bus.intf_chipset_rdy_noc3}, pkt_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); // select register restarted at 00
        drive(3'b001, GOOD);
        n_checks++;
        if ({pkt_cnt, err_cnt} !== {16'd1, 8'd0}) begin
            n_errors++; $display("FAIL after_mid_reset got pkt=%0d err=%0d want 1 0",
                pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_clr();
        clr = 1'b1;
        drive(3'b001, GOOD);
        clr = 1'b0;
        n_checks++;
        if ({pkt_cnt, last_hdr} !== {16'd0, 64'd0}) begin
            n_errors++; $display("FAIL clr_priority got pkt=%0d hdr=%h want 0 0", pkt_cnt, last_hdr);
        end
        drive(3'b001, mk_hdr(14'h2000, 4'b0010, 8'd3, 8'd18, 6'd0));
        drive(3'b001, 64'h9);
        do_clr();
        drive(3'b001, GOOD);
        n_checks++;
        if ({pkt_cnt, last_hdr} !== {16'd1, GOOD}) begin
            n_errors++; $display("FAIL clr_fsm got pkt=%0d hdr=%h want 1 %h", pkt_cnt, last_hdr, GOOD);
        end
    endtask

    task automatic test_err_sat();
        do_clr();
        for (int i = 0; i < 300; i++) drive(3'b001, mk_hdr(14'h2000, 4'b0010, 8'd0, 8'd19, 6'd0));
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag} !== {16'd300, 8'hFF, 1'b1}) begin
            n_errors++; $display("FAIL err_sat got pkt=%0d err=%h flag=%b want 300 ff 1",
                pkt_cnt, err_cnt, err_flag);
        end
    endtask

    task automatic test_payload_idle();
        do_clr();
        drive(3'b001, mk_hdr(14'h2000, 4'b0010, 8'd2, 8'd18, 6'd0));
        drive(3'b001, 64'h1);
`ifdef POLARA_LOOPBACK_CHK_TIMEOUT_EN
        repeat (15) @(negedge clk);
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_errors++; $display("FAIL timeout_early got err=%0d want 0", err_cnt);
        end
        @(negedge clk);
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag} !== {16'd0, 8'd1, 1'b1}) begin
            n_errors++; $display("FAIL timeout got pkt=%0d err=%0d flag=%b want 0 1 1",
                pkt_cnt, err_cnt, err_flag);
        end
        drive(3'b001, GOOD);
        n_checks++;
        if (pkt_cnt !== 16'd1) begin
            n_errors++; $display("FAIL after_timeout got pkt=%0d want 1", pkt_cnt);
        end
`else
        repeat (40) @(negedge clk);
        n_checks++;
        if ({pkt_cnt, err_cnt} !== {16'd0, 8'd0}) begin
            n_errors++; $display("FAIL idle_wait got pkt=%0d err=%0d want 0 0", pkt_cnt, err_cnt);
        end
        drive(3'b001, 64'h2);
        n_checks++;
        if ({pkt_cnt, err_cnt, last_hdr[29:22]} !== {16'd1, 8'd0, 8'd2}) begin
            n_errors++; $display("FAIL idle_resume got pkt=%0d err=%0d len=%0d want 1 0 2",
                pkt_cnt, err_cnt, last_hdr[29:22]);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int rdy_bad;
        rdy_bad = 0;
        do_clr();
        set_sel(2'b11);
        for (int i = 0; i < 70000; i++) begin
            drive(3'b111, GOOD);
            if ({bus.intf_chipset_rdy_noc1, bus.intf_chipset_rdy_noc2,
                 bus.intf_chipset_rdy_noc3} !== 3'b111) rdy_bad++;
            if (i == 999) begin
                n_checks++;
                if (pkt_cnt !== 16'd1000) begin
                    n_errors++; $display("FAIL b2b_1000 got pkt=%0d want 1000", pkt_cnt);
                end
            end
        end
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flag} !== {16'hFFFF, 8'd0, 1'b0}) begin
            n_errors++; $display("FAIL pkt_sat got pkt=%h err=%0d flag=%b want ffff 0 0",
                pkt_cnt, err_cnt, err_flag);
        end
        n_checks++;
        if (rdy_bad !== 0) begin
            n_errors++; $display("FAIL rdy_stream got %0d low cycles want 0", rdy_bad);
        end
    endtask

    initial begin
        bus.intf_chipset_data_noc1 = 64'd0;
        bus.intf_chipset_data_noc2 = 64'd0;
        bus.intf_chipset_data_noc3 = 64'd0;
        bus.intf_chipset_val_noc1  = 1'b0;
        bus.intf_chipset_val_noc2  = 1'b0;
        bus.intf_chipset_val_noc3  = 1'b0;
        test_reset();
        test_good();
        test_bad_msg();
        test_checks();
        test_unselected();
        test_sel_change();
        test_reset_mid();
        test_clr();
        test_err_sat();
        test_payload_idle();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
